// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the write-back path: widths, MEM/WB control word
// bit positions, the arbiter state encoding and the MDU result FIFO payload.
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  // Bit positions inside the 2-bit MEM/WB control word
  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef logic [1:0] wb_ctrl_t;

  typedef enum logic {
    ARB   = 1'b0,
    DRAIN = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic [XLEN-1:0]   data;
  } mdu_entry_t;

endpackage

// File: rtl/mux2_32.sv
// Generic 32-bit 2:1 multiplexer.
//   sel : 0 selects d0, 1 selects d1
//   d0  : input 0
//   d1  : input 1
//   y   : selected value
module mux2_32 (
  input  logic        sel,
  input  logic [31:0] d0,
  input  logic [31:0] d1,
  output logic [31:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/wb_result_fifo.sv
// Small FIFO buffering MDU results until they win the register-file port.
//   clk, reset : clock, synchronous active-high reset (drops all entries)
//   push       : store push_entry (ignored when full)
//   push_entry : {dest, data} to store
//   pop        : discard the head entry (ignored when empty)
//   head       : oldest stored entry, valid when !empty
//   full/empty : occupancy flags
module wb_result_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  mdu_entry_t push_entry,
  input  logic       pop,
  output mdu_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  mdu_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Storage carries no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between pipeline write-back and
// buffered MDU results. The pipeline always wins; after STARVE_LIMIT
// consecutive MDU losses pipe_stall is raised until a pipeline bubble lets
// the MDU head through.
//   clk, reset      : clock, synchronous active-high reset
//   pipe_wb_ctrl    : {RegWrite, MemtoReg}
//   pipe_read_data  : load data (MemtoReg=1)
//   pipe_alu_result : ALU result (MemtoReg=0)
//   pipe_dest       : pipeline destination register
//   mdu_valid/dest/result : MDU result offer
//   mdu_ready       : FIFO not full (combinational from state)
//   pipe_stall      : upstream must insert WB bubbles
//   rf_we/waddr/wdata : registered register-file write port
module wb_port_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  pipe_wb_ctrl,
  input  logic [31:0] pipe_read_data,
  input  logic [31:0] pipe_alu_result,
  input  logic [4:0]  pipe_dest,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_dest,
  input  logic [31:0] mdu_result,
  output logic        mdu_ready,
  output logic        pipe_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

  wb_ctrl_t    wb_ctrl;
  arb_state_t  state_q;
  arb_state_t  state_d;
  logic [SCW-1:0] starve_cnt;
  logic [SCW-1:0] starve_cnt_d;

  logic        pipe_req;
  logic        mdu_req;
  logic        grant_pipe;
  logic        grant_mdu;
  logic        starve_hit;
  logic [31:0] pipe_data;

  logic        fifo_push;
  logic        fifo_full;
  logic        fifo_empty;
  mdu_entry_t  fifo_in;
  mdu_entry_t  fifo_head;

  logic        rf_we_d;
  logic [4:0]  rf_waddr_d;
  logic [31:0] rf_wdata_d;
  logic        pipe_stall_d;

  assign wb_ctrl = pipe_wb_ctrl;

  mux2_32 u_pipe_sel (
    .sel (wb_ctrl[WB_MEMTOREG]),
    .d0  (pipe_alu_result),
    .d1  (pipe_read_data),
    .y   (pipe_data)
  );

  // Writes to x0 from the MDU are dropped at the door
  assign mdu_ready = !fifo_full;
  assign fifo_push = mdu_valid && mdu_ready && (mdu_dest != REG_ZERO);
  assign fifo_in   = '{dest: mdu_dest, data: mdu_result};

  wb_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_entry (fifo_in),
    .pop        (grant_mdu),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign pipe_req = wb_ctrl[WB_REGWRITE] && (pipe_dest != REG_ZERO);
  assign mdu_req  = !fifo_empty;

  // This cycle is the STARVE_LIMIT-th consecutive MDU loss
  assign starve_hit = pipe_req && mdu_req && (starve_cnt >= STARVE_MAX - SCW'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ARB;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:   if (starve_hit) state_d = DRAIN;
      DRAIN: if (!pipe_req || !mdu_req) state_d = ARB;
    endcase
  end

  // Grant, starvation counter and write-port next values
  always_comb begin
    grant_pipe   = 1'b0;
    grant_mdu    = 1'b0;
    starve_cnt_d = starve_cnt;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr;
    rf_wdata_d   = rf_wdata;
    pipe_stall_d = 1'b0;

    grant_pipe = pipe_req;
    grant_mdu  = !pipe_req && mdu_req;

    if (grant_pipe) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_dest;
      rf_wdata_d = pipe_data;
    end else if (grant_mdu) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = fifo_head.dest;
      rf_wdata_d = fifo_head.data;
    end

    if (grant_mdu) begin
      starve_cnt_d = '0;
    end else if (pipe_req && mdu_req && (starve_cnt != STARVE_MAX)) begin
      starve_cnt_d = starve_cnt + SCW'(1);
    end

    pipe_stall_d = (state_d == DRAIN);
  end

  // Output and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      pipe_stall <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_d;
      rf_we      <= rf_we_d;
      rf_waddr   <= rf_waddr_d;
      rf_wdata   <= rf_wdata_d;
      pipe_stall <= pipe_stall_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: per-cycle vectors with hand-derived
// expected outputs, queued when driven and compared after the clock edge.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  pipe_wb_ctrl;
  logic [31:0] pipe_read_data;
  logic [31:0] pipe_alu_result;
  logic [4:0]  pipe_dest;
  logic        mdu_valid;
  logic [4:0]  mdu_dest;
  logic [31:0] mdu_result;
  logic        mdu_ready;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic [1:0]  ctrl;
    logic [4:0]  pdest;
    logic [31:0] rd;
    logic [31:0] alu;
    logic        mv;
    logic [4:0]  mdest;
    logic [31:0] mres;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        ready;
    logic        stall;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        ready;
    logic        stall;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];

  wb_port_arbiter #(
    .DEPTH        (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pipe_wb_ctrl    (pipe_wb_ctrl),
    .pipe_read_data  (pipe_read_data),
    .pipe_alu_result (pipe_alu_result),
    .pipe_dest       (pipe_dest),
    .mdu_valid       (mdu_valid),
    .mdu_dest        (mdu_dest),
    .mdu_result      (mdu_result),
    .mdu_ready       (mdu_ready),
    .pipe_stall      (pipe_stall),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic rst, input logic [1:0] ctrl,
                              input logic [4:0] pdest, input logic [31:0] rd,
                              input logic [31:0] alu, input logic mv,
                              input logic [4:0] mdest, input logic [31:0] mres,
                              input logic we, input logic [4:0] waddr,
                              input logic [31:0] wdata, input logic ready,
                              input logic stall);
    vec_t v;
    v.rst = rst; v.ctrl = ctrl; v.pdest = pdest; v.rd = rd; v.alu = alu;
    v.mv = mv; v.mdest = mdest; v.mres = mres;
    v.we = we; v.waddr = waddr; v.wdata = wdata; v.ready = ready; v.stall = stall;
    return v;
  endfunction

  task automatic check(input string name, input string tag,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%s: got 0x%08h expected 0x%08h", name, tag, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    reset           = v.rst;
    pipe_wb_ctrl    = v.ctrl;
    pipe_dest       = v.pdest;
    pipe_read_data  = v.rd;
    pipe_alu_result = v.alu;
    mdu_valid       = v.mv;
    mdu_dest        = v.mdest;
    mdu_result      = v.mres;
    e.we = v.we; e.waddr = v.waddr; e.wdata = v.wdata;
    e.ready = v.ready; e.stall = v.stall;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard @%s: no expectation queued", tag);
    end else begin
      e = exp_q.pop_front();
      check("rf_we",      tag, 32'(rf_we),      32'(e.we));
      check("rf_waddr",   tag, 32'(rf_waddr),   32'(e.waddr));
      check("rf_wdata",   tag, rf_wdata,        e.wdata);
      check("mdu_ready",  tag, 32'(mdu_ready),  32'(e.ready));
      check("pipe_stall", tag, 32'(pipe_stall), 32'(e.stall));
    end
  endtask

  initial begin
    reset = 1'b1;
    pipe_wb_ctrl = 2'b00; pipe_dest = '0; pipe_read_data = '0;
    pipe_alu_result = '0; mdu_valid = 1'b0; mdu_dest = '0; mdu_result = '0;

    // Reset held for two cycles
    apply(mk(1, 2'b00, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0), "reset0");
    apply(mk(1, 2'b00, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0), "reset1");

    //            rst ctrl  pdst rd            alu          mv md  mres      we wa  wdata        rdy stl
    // Pipe write-back: data select, x0 and RegWrite=0 suppression
    tbl.push_back(mk(0, 2'b11, 5,  32'hDEADBEEF, 32'h0,       0, 0,  32'h0,     1, 5,  32'hDEADBEEF, 1, 0));
    tbl.push_back(mk(0, 2'b10, 5,  32'h0,        32'h1234,    0, 0,  32'h0,     1, 5,  32'h1234,     1, 0));
    tbl.push_back(mk(0, 2'b10, 0,  32'h0,        32'hAAAA,    0, 0,  32'h0,     0, 5,  32'h1234,     1, 0));
    tbl.push_back(mk(0, 2'b01, 9,  32'h777,      32'h888,     0, 0,  32'h0,     0, 5,  32'h1234,     1, 0));
    tbl.push_back(mk(0, 2'b11, 31, 32'hCAFEF00D, 32'h1,       0, 0,  32'h0,     1, 31, 32'hCAFEF00D, 1, 0));
    // MDU result to x0 is accepted and discarded
    tbl.push_back(mk(0, 2'b00, 0,  32'h0,        32'h0,       1, 0,  32'h99,    0, 31, 32'hCAFEF00D, 1, 0));
    tbl.push_back(mk(0, 2'b00, 0,  32'h0,        32'h0,       0, 0,  32'h0,     0, 31, 32'hCAFEF00D, 1, 0));
    // Two MDU pushes with the pipe idle: written back to back, oldest first
    tbl.push_back(mk(0, 2'b00, 0,  32'h0,        32'h0,       1, 7,  32'h55,    0, 31, 32'hCAFEF00D, 1, 0));
    tbl.push_back(mk(0, 2'b00, 0,  32'h0,        32'h0,       1, 8,  32'h66,    1, 7,  32'h55,       1, 0));
    tbl.push_back(mk(0, 2'b00, 0,  32'h0,        32'h0,       0, 0,  32'h0,     1, 8,  32'h66,       1, 0));
    tbl.push_back(mk(0, 2'b00, 0,  32'h0,        32'h0,       0, 0,  32'h0,     0, 8,  32'h66,       1, 0));
    // Fill the FIFO behind pipe writes; offer while full is not taken
    tbl.push_back(mk(0, 2'b10, 10, 32'h0,        32'hA1,      1, 7,  32'h55,    1, 10, 32'hA1,       1, 0));
    tbl.push_back(mk(0, 2'b10, 11, 32'h0,        32'hA2,      1, 8,  32'h66,    1, 11, 32'hA2,       0, 0));
    tbl.push_back(mk(0, 2'b00, 0,  32'h0,        32'h0,       1, 9,  32'h77,    1, 7,  32'h55,       1, 0));
    tbl.push_back(mk(0, 2'b00, 0,  32'h0,        32'h0,       0, 0,  32'h0,     1, 8,  32'h66,       1, 0));
    tbl.push_back(mk(0, 2'b00, 0,  32'h0,        32'h0,       0, 0,  32'h0,     0, 8,  32'h66,       1, 0));
    // Starvation: one buffered entry, pipe writes every cycle
    tbl.push_back(mk(0, 2'b10, 12, 32'h0,        32'hB0,      1, 13, 32'hC0,    1, 12, 32'hB0,       1, 0));
    tbl.push_back(mk(0, 2'b10, 12, 32'h0,        32'hB1,      0, 0,  32'h0,     1, 12, 32'hB1,       1, 0));
    tbl.push_back(mk(0, 2'b10, 12, 32'h0,        32'hB2,      0, 0,  32'h0,     1, 12, 32'hB2,       1, 0));
    tbl.push_back(mk(0, 2'b10, 12, 32'h0,        32'hB3,      0, 0,  32'h0,     1, 12, 32'hB3,       1, 0));
    tbl.push_back(mk(0, 2'b10, 12, 32'h0,        32'hB4,      0, 0,  32'h0,     1, 12, 32'hB4,       1, 1));
    // DRAIN with the pipe still writing: pipe wins, stall holds
    tbl.push_back(mk(0, 2'b11, 14, 32'hD0,       32'h0,       0, 0,  32'h0,     1, 14, 32'hD0,       1, 1));
    tbl.push_back(mk(0, 2'b10, 15, 32'h0,        32'hD1,      1, 16, 32'hE0,    1, 15, 32'hD1,       0, 1));
    tbl.push_back(mk(0, 2'b10, 15, 32'h0,        32'hD2,      0, 0,  32'h0,     1, 15, 32'hD2,       0, 1));
    // Bubble: MDU head written, stall drops, then the second entry
    tbl.push_back(mk(0, 2'b00, 0,  32'h0,        32'h0,       0, 0,  32'h0,     1, 13, 32'hC0,       1, 0));
    tbl.push_back(mk(0, 2'b00, 0,  32'h0,        32'h0,       0, 0,  32'h0,     1, 16, 32'hE0,       1, 0));
    tbl.push_back(mk(0, 2'b00, 0,  32'h0,        32'h0,       0, 0,  32'h0,     0, 16, 32'hE0,       1, 0));
    // RegWrite to x0 is no request, so the MDU gets the port
    tbl.push_back(mk(0, 2'b00, 0,  32'h0,        32'h0,       1, 17, 32'hF7,    0, 16, 32'hE0,       1, 0));
    tbl.push_back(mk(0, 2'b11, 0,  32'hBAD,      32'h0,       0, 0,  32'h0,     1, 17, 32'hF7,       1, 0));
    tbl.push_back(mk(0, 2'b00, 0,  32'h0,        32'h0,       0, 0,  32'h0,     0, 17, 32'hF7,       1, 0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset while the FIFO is full and pipe_stall is high
    apply(mk(0, 2'b10, 20, 32'h0, 32'hF0, 1, 21, 32'h11,  1, 20, 32'hF0, 1, 0), "rst_fill0");
    apply(mk(0, 2'b10, 20, 32'h0, 32'hF1, 1, 22, 32'h22,  1, 20, 32'hF1, 0, 0), "rst_fill1");
    apply(mk(0, 2'b10, 20, 32'h0, 32'hF2, 0, 0,  32'h0,   1, 20, 32'hF2, 0, 0), "rst_fill2");
    apply(mk(0, 2'b10, 20, 32'h0, 32'hF3, 0, 0,  32'h0,   1, 20, 32'hF3, 0, 0), "rst_fill3");
    apply(mk(0, 2'b10, 20, 32'h0, 32'hF4, 0, 0,  32'h0,   1, 20, 32'hF4, 0, 1), "rst_stall");
    apply(mk(1, 2'b10, 20, 32'h0, 32'hF5, 1, 23, 32'h33,  0, 0,  32'h0,  1, 0), "rst_pulse");
    apply(mk(0, 2'b00, 0,  32'h0, 32'h0,  0, 0,  32'h0,   0, 0,  32'h0,  1, 0), "rst_after0");
    apply(mk(0, 2'b00, 0,  32'h0, 32'h0,  0, 0,  32'h0,   0, 0,  32'h0,  1, 0), "rst_after1");
    apply(mk(0, 2'b10, 2,  32'h0, 32'h42, 0, 0,  32'h0,   1, 2,  32'h42, 1, 0), "rst_resume");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
